id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register, the successor of the fixed-width dual-edge ID/EX latch. All state updates on the rising edge of a single clock. Generic operand count and field widths; explicit valid bit; bubble insertion for load-use hazards; cache-stall hold; branch flush that is never lost during a stall; resolved destination address; saturating stall and bubble counters for performance debug. Sits between the decode stage / hazard unit and the execute stage / forwarding unit.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 19 +
 rtl/id_ex_pipe_reg.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX control field layout, default widths and
// the WB/MEM control bundle reused by the later pipeline registers.
package pipe_pkg;

  localparam int DATA_W_D  = 32;
  localparam int AW_D      = 5;
  localparam int WB_W_D    = 2;
  localparam int MEM_W_D   = 2;
  localparam int ALUOP_W_D = 2;
  localparam int CNT_W_D   = 16;

  // EX field is {alu_src, alu_op, reg_dst}; alu_src sits just above alu_op
  localparam int REG_DST_BIT = 0;
  localparam int ALU_OP_LSB  = 1;
  localparam int ALU_SRC_BIT = ALU_OP_LSB + ALUOP_W_D;

  typedef struct packed {
    logic [WB_W_D-1:0]  wb;
    logic [MEM_W_D-1:0] mem;
  } wbmem_ctrl_t;

  function automatic int alu_src_bit(input int aluop_w);
    return ALU_OP_LSB + aluop_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for pipeline performance debug.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, bubble insertion, sticky flush
// across stalls, resolved destination address and debug counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int AW      = AW_D,
  parameter int NUM_SRC = 2,
  parameter int WB_W    = WB_W_D,
  parameter int MEM_W   = MEM_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int CNT_W   = CNT_W_D,
  localparam int EX_W   = ALUOP_W + 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      bubble_i,
  input  logic                      valid_i,
  input  logic [WB_W-1:0]           wb_i,
  input  logic [MEM_W-1:0]          mem_i,
  input  logic [EX_W-1:0]           ex_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  input  logic [NUM_SRC*AW-1:0]     src_addr_i,
  input  logic [AW-1:0]             rt_addr_i,
  input  logic [AW-1:0]             rd_addr_i,
  input  logic [DATA_W-1:0]         immd_i,
  output logic                      valid_o,
  output logic [WB_W-1:0]           wb_o,
  output logic [MEM_W-1:0]          mem_o,
  output logic                      alu_src_o,
  output logic [ALUOP_W-1:0]        alu_op_o,
  output logic                      reg_dst_o,
  output logic [NUM_SRC*DATA_W-1:0] src_data_o,
  output logic [NUM_SRC*AW-1:0]     src_addr_o,
  output logic [AW-1:0]             rt_addr_o,
  output logic [AW-1:0]             rd_addr_o,
  output logic [DATA_W-1:0]         immd_o,
  output logic [AW-1:0]             dst_addr_o,
  output logic                      flush_pend_o,
  output logic [CNT_W-1:0]          stall_cnt_o,
  output logic [CNT_W-1:0]          bubble_cnt_o
);

  localparam int ALU_SRC_POS = alu_src_bit(ALUOP_W);

  logic flush_eff;
  logic kill;
  logic bubble_inc;

  assign flush_eff  = flush_i | flush_pend_o;
  assign kill       = flush_eff | bubble_i | ~valid_i;
  // an idle decode slot (valid_i low) is not counted as an inserted bubble
  assign bubble_inc = ~stall_i & (flush_eff | bubble_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o      <= 1'b0;
      wb_o         <= '0;
      mem_o        <= '0;
      alu_src_o    <= 1'b0;
      alu_op_o     <= '0;
      reg_dst_o    <= 1'b0;
      src_data_o   <= '0;
      src_addr_o   <= '0;
      rt_addr_o    <= '0;
      rd_addr_o    <= '0;
      immd_o       <= '0;
      dst_addr_o   <= '0;
      flush_pend_o <= 1'b0;
    end else if (stall_i) begin
      if (flush_i) flush_pend_o <= 1'b1;
    end else begin
      flush_pend_o <= 1'b0;
      if (kill) begin
        // payload holds; only control is zeroed so no write can escape
        valid_o   <= 1'b0;
        wb_o      <= '0;
        mem_o     <= '0;
        alu_src_o <= 1'b0;
        alu_op_o  <= '0;
        reg_dst_o <= 1'b0;
      end else begin
        valid_o    <= 1'b1;
        wb_o       <= wb_i;
        mem_o      <= mem_i;
        alu_src_o  <= ex_i[ALU_SRC_POS];
        alu_op_o   <= ex_i[ALU_OP_LSB +: ALUOP_W];
        reg_dst_o  <= ex_i[REG_DST_BIT];
        src_data_o <= src_data_i;
        src_addr_o <= src_addr_i;
        rt_addr_o  <= rt_addr_i;
        rd_addr_o  <= rd_addr_i;
        immd_o     <= immd_i;
        dst_addr_o <= ex_i[REG_DST_BIT] ? rd_addr_i : rt_addr_i;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

endmodule
